cdm_prod_acc: RTL
=================

CDM_PROD_ACC -- requirements
Module: cdm_prod_acc

Interface
REQ-001 SHALL have parameter ACC_W, default 40, accumulator and result width (minimum 32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the beat-count input.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin an accumulation.
REQ-006 SHALL have port len  input  CNT_W  number of products to accumulate; sampled with start.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current operation.
REQ-008 SHALL have port p_valid  input  1  upstream product beat valid.
REQ-009 SHALL have port p_data  input  32  unsigned 16x16 approximate product.
REQ-010 SHALL have port p_ready  output  1  block accepts a product beat.
REQ-011 SHALL have port r_valid  output  1  result valid.
REQ-012 SHALL have port r_data  output  ACC_W  accumulated sum.
REQ-013 SHALL have port r_ready  input  1  downstream accepts the result.
REQ-014 SHALL have port r_ovf  output  1  a carry out of ACC_W occurred during this accumulation.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement states IDLE, ACC, HOLD.
REQ-017 IDLE: p_ready=0, r_valid=0; start with len!=0 -> ACC next cycle, acc<=0, cnt<=len, ovf<=0.
REQ-018 IDLE: start with len==0 -> HOLD next cycle with acc=0, ovf=0.
REQ-019 start SHALL be ignored in ACC and HOLD.
REQ-020 ACC: p_ready=1; beat accepted when p_valid and p_ready are both high in the same cycle.
REQ-021 Per accepted beat: acc<=(acc + zero-extended p_data) mod 2^ACC_W, ovf<=ovf | carry-out, cnt<=cnt-1.
REQ-022 Beat accepted while cnt==1 -> HOLD next cycle, so r_valid rises exactly one cycle after the final beat.
REQ-023 ACC with p_valid low SHALL hold acc and cnt unchanged, with no timeout.
REQ-024 HOLD: r_valid=1, p_ready=0, r_data=acc, r_ovf=ovf; all three stable until r_ready is high.
REQ-025 HOLD with r_ready high -> IDLE next cycle.
REQ-026 r_data and r_ovf SHALL continue to show the last result in IDLE until the next start.
REQ-027 abort high in any state -> IDLE next cycle, with acc=0, ovf=0, cnt=0.
REQ-028 abort SHALL take priority over start, beat acceptance and r_ready in the same cycle.
REQ-029 p_ready and r_valid SHALL be decoded from registered state only, with no combinational path from p_valid or r_ready.
REQ-030 busy=1 in ACC and HOLD.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE, acc=0, cnt=0, ovf=0.
REQ-032 During reset, outputs SHALL be p_ready=0, r_valid=0, r_data=0, r_ovf=0, busy=0.
REQ-033 Reset deassertion SHALL take effect at the next clk edge, and the block SHALL accept start on that edge.
REQ-034 Reset mid-operation SHALL discard partial sums, with no result emitted.

Structure
REQ-035 Shared package cdm_pkg SHALL hold the state enum (IDLE, ACC, HOLD), the product width constant (32) and the ACC_W default.
REQ-036 A single sub-module cdm_acc_add SHALL provide the ACC_W-bit add of acc and zero-extended p_data with carry-out.
REQ-037 The FSM, counter and registers SHALL reside in cdm_prod_acc.

Verification
REQ-038 len=3; beats 0x0001_0000, 0x0000_FFFF, 0x0000_0001 with p_valid continuous -> r_valid one cycle after the third beat, r_data=0x00_0002_0000, r_ovf=0.
REQ-039 ACC_W=32; len=2; beats 0xFFFF_FFFF, 0x0000_0002 -> r_data=0x0000_0001, r_ovf=1.
REQ-040 start with len=0 -> no p_ready, r_valid=1 next cycle, r_data=0, r_ovf=0.
REQ-041 len=2; p_valid gapped 3 cycles between beats, then r_ready low for 5 cycles -> r_data stable, p_ready=0, and IDLE one cycle after r_ready rises.
REQ-042 len=4; abort after 2 beats; then start len=1 with beat 0x5 -> r_data=0x5, r_ovf=0, with no residue from the aborted run.
REQ-043 rst_n pulsed low mid-ACC -> all outputs zero immediately (asynchronously); a subsequent start len=1 with beat 0x7 -> r_data=0x7.

Source files
------------

// File: rtl/cdm_pkg.sv
// Shared definitions for the product accumulator.
//   cdm_state_e : accumulator FSM state encoding (IDLE, ACC, HOLD)
//   PROD_W      : width of one incoming approximate product beat
//   ACC_W_DEF   : default accumulator / result width
package cdm_pkg;

    localparam int PROD_W    = 32;
    localparam int ACC_W_DEF = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } cdm_state_e;

endpackage

// File: rtl/cdm_acc_add.sv
// ACC_W-bit adder: accumulator plus zero-extended product, with carry-out.
//   acc   : current accumulator value
//   prod  : unsigned product beat (PROD_W bits, zero-extended)
//   sum   : (acc + prod) mod 2^ACC_W
//   carry : carry out of bit ACC_W-1
module cdm_acc_add
    import cdm_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] prod_ext_s;
    logic [ACC_W:0] full_s;

    // Zero-extend the product and form the ACC_W+1 bit sum.
    always_comb begin
        prod_ext_s               = '0;
        prod_ext_s[PROD_W-1:0]   = prod;
        full_s                   = {1'b0, acc} + prod_ext_s;
        sum                      = full_s[ACC_W-1:0];
        carry                    = full_s[ACC_W];
    end

endmodule

// File: rtl/cdm_prod_acc.sv
// Product accumulator: sums `len` unsigned product beats and presents the
// total with a sticky overflow flag through a valid/ready result port.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start, len     : begin an accumulation of len beats (len==0 -> empty result)
//   abort          : synchronous cancel, returns to IDLE with cleared state
//   p_valid/p_data/p_ready : product beat input handshake
//   r_valid/r_data/r_ovf/r_ready : result output handshake
//   busy           : high outside IDLE
module cdm_prod_acc
    import cdm_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              abort,
    input  logic              p_valid,
    input  logic [PROD_W-1:0] p_data,
    output logic              p_ready,
    output logic              r_valid,
    output logic [ACC_W-1:0]  r_data,
    input  logic              r_ready,
    output logic              r_ovf,
    output logic              busy
);

    cdm_state_e       state_r;
    cdm_state_e       next_state_s;
    logic [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;
    logic [ACC_W-1:0] sum_s;
    logic             carry_s;
    logic             beat_s;

    cdm_acc_add #(.ACC_W(ACC_W)) u_add (
        .acc   (acc_r),
        .prod  (p_data),
        .sum   (sum_s),
        .carry (carry_s)
    );

    // Beat acceptance; p_ready is itself a decode of state_r.
    always_comb begin
        beat_s = (state_r == ACC) && p_valid;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        next_state_s = state_r;
        if (abort) begin
            next_state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        next_state_s = (len == '0) ? HOLD : ACC;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                ACC: begin
                    if (beat_s && (cnt_r == CNT_W'(1))) begin
                        next_state_s = HOLD;
                    end else begin
                        next_state_s = ACC;
                    end
                end
                HOLD: begin
                    if (r_ready) begin
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = HOLD;
                    end
                end
                default: next_state_s = IDLE;
            endcase
        end
    end

    // Accumulator, beat counter and sticky overflow; the result is kept in
    // IDLE so it remains visible until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (abort) begin
            acc_r <= '0;
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        acc_r <= '0;
                        cnt_r <= len;
                        ovf_r <= 1'b0;
                    end
                end
                ACC: begin
                    if (beat_s) begin
                        acc_r <= sum_s;
                        cnt_r <= cnt_r - CNT_W'(1);
                        ovf_r <= ovf_r | carry_s;
                    end
                end
                HOLD: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= '0;
                    cnt_r <= '0;
                    ovf_r <= 1'b0;
                end
            endcase
        end
    end

    // Output decode from registered state and datapath only.
    always_comb begin
        p_ready = 1'b0;
        r_valid = 1'b0;
        busy    = 1'b0;
        case (state_r)
            IDLE: begin
                p_ready = 1'b0;
                r_valid = 1'b0;
                busy    = 1'b0;
            end
            ACC: begin
                p_ready = 1'b1;
                busy    = 1'b1;
            end
            HOLD: begin
                r_valid = 1'b1;
                busy    = 1'b1;
            end
            default: begin
                p_ready = 1'b0;
                r_valid = 1'b0;
                busy    = 1'b0;
            end
        endcase
        r_data = acc_r;
        r_ovf  = ovf_r;
    end

endmodule
